// File: rtl/johnson_counter_param.sv
// Parameterised Johnson counter: bidirectional stepping, synchronous load,
// wrap/load-error pulses and combinational index/one-hot decode of q.
module johnson_counter_param #(
    parameter int WIDTH        = 4,
    parameter int SELF_CORRECT = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          up_down,
    input  logic                          load,
    input  logic [WIDTH-1:0]              load_data,
    output logic [WIDTH-1:0]              q,
    output logic [$clog2(2*WIDTH)-1:0]    state_index,
    output logic [2*WIDTH-1:0]            decode,
    output logic                          wrap,
    output logic                          illegal,
    output logic                          load_err
);

    localparam int N  = 2 * WIDTH;
    localparam int IW = $clog2(N);

    // k < = WIDTH: k low ones; beyond that: all ones with (k-WIDTH) low zeros
    function automatic logic [WIDTH-1:0] pat(input int k);
        logic [WIDTH-1:0] ones;
        ones = '1;
        if (k <= WIDTH) pat = (k == WIDTH) ? ones : ~(ones << k);
        else            pat = ones << (k - WIDTH);
    endfunction

    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        is_legal = 1'b0;
        for (int k = 0; k < N; k++)
            if (v == pat(k)) is_legal = 1'b1;
    endfunction

    logic [WIDTH-1:0] last_pat;
    logic [WIDTH-1:0] next_q;
    logic             next_wrap;
    logic             next_lerr;
    logic             ld_legal;

    assign last_pat = pat(N - 1);
    assign ld_legal = is_legal(load_data);

    always_comb begin
        state_index = '0;
        decode      = '0;
        for (int k = 0; k < N; k++) begin
            if (q == pat(k)) begin
                decode[k]   = 1'b1;
                state_index = IW'(k);
            end
        end
        illegal = ~(|decode);
    end

    always_comb begin
        next_q    = q;
        next_wrap = 1'b0;
        next_lerr = 1'b0;
        priority case (1'b1)
            load: begin
                if (SELF_CORRECT != 0 && !ld_legal) begin
                    next_q    = '0;
                    next_lerr = 1'b1;
                end else begin
                    next_q = load_data;
                end
            end
            enable: begin
                if (up_down) begin
                    next_q    = {q[WIDTH-2:0], ~q[WIDTH-1]};
                    next_wrap = (q == last_pat);
                end else begin
                    next_q    = {~q[0], q[WIDTH-1:1]};
                    next_wrap = (q == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q        <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q        <= next_q;
            wrap     <= next_wrap;
            load_err <= next_lerr;
        end
    end

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed bench for johnson_counter_param: WIDTH=4 with and without
// self-correction, plus the WIDTH=2 minimum.
module tb_johnson_counter_param;

    logic clock;
    logic reset;

    logic       enable, up_down, load;
    logic [3:0] load_data;
    logic [3:0] q;
    logic [2:0] state_index;
    logic [7:0] decode;
    logic       wrap, illegal, load_err;

    logic       en_nc, ud_nc, ld_nc;
    logic [3:0] ldd_nc;
    logic [3:0] q_nc;
    logic [2:0] idx_nc;
    logic [7:0] dec_nc;
    logic       wrap_nc, ill_nc, lerr_nc;

    logic       en2, ud2, ld2;
    logic [1:0] ldd2;
    logic [1:0] q2;
    logic [1:0] idx2;
    logic [3:0] dec2;
    logic       wrap2, ill2, lerr2;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] fw [8];
    logic [1:0] fw2 [4];

    johnson_counter_param #(.WIDTH(4), .SELF_CORRECT(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_data(load_data), .q(q),
        .state_index(state_index), .decode(decode), .wrap(wrap),
        .illegal(illegal), .load_err(load_err)
    );

    johnson_counter_param #(.WIDTH(4), .SELF_CORRECT(0)) dut_nc (
        .clock(clock), .reset(reset), .enable(en_nc), .up_down(ud_nc),
        .load(ld_nc), .load_data(ldd_nc), .q(q_nc),
        .state_index(idx_nc), .decode(dec_nc), .wrap(wrap_nc),
        .illegal(ill_nc), .load_err(lerr_nc)
    );

    johnson_counter_param #(.WIDTH(2), .SELF_CORRECT(1)) dut2 (
        .clock(clock), .reset(reset), .enable(en2), .up_down(ud2),
        .load(ld2), .load_data(ldd2), .q(q2),
        .state_index(idx2), .decode(dec2), .wrap(wrap2),
        .illegal(ill2), .load_err(lerr2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        fw  = '{4'h1, 4'h3, 4'h7, 4'hf, 4'he, 4'hc, 4'h8, 4'h0};
        fw2 = '{2'b01, 2'b11, 2'b10, 2'b00};
        reset = 1'b1;
        enable = 0; up_down = 0; load = 0; load_data = '0;
        en_nc = 0; ud_nc = 0; ld_nc = 0; ldd_nc = '0;
        en2 = 0; ud2 = 0; ld2 = 0; ldd2 = '0;

        #2;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_lerr", 32'(load_err), 32'h0);
        chk("rst_idx", 32'(state_index), 32'h0);
        chk("rst_dec", 32'(decode), 32'h01);
        chk("rst_ill", 32'(illegal), 32'h0);

        #8;
        reset = 1'b0;
        enable = 1; up_down = 1;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk($sformatf("fw_q%0d", i), 32'(q), 32'(fw[i]));
            chk($sformatf("fw_wrap%0d", i), 32'(wrap), 32'(i == 7));
            chk($sformatf("fw_dec%0d", i), 32'(decode),
                32'h1 << ((i + 1) % 8));
            chk($sformatf("fw_idx%0d", i), 32'(state_index),
                32'((i + 1) % 8));
        end

        // async reset between edges, then count backward
        #3 reset = 1'b1;
        #1 chk("rst2_q", 32'(q), 32'h0);
        reset = 1'b0;
        up_down = 0;
        tick;
        chk("bk_q0", 32'(q), 32'h8);
        chk("bk_wrap0", 32'(wrap), 32'h1);
        chk("bk_idx0", 32'(state_index), 32'h7);
        tick;
        chk("bk_q1", 32'(q), 32'hc);
        chk("bk_wrap1", 32'(wrap), 32'h0);
        chk("bk_idx1", 32'(state_index), 32'h6);
        up_down = 1;
        tick;
        chk("flip_up_q", 32'(q), 32'h8);
        chk("flip_up_wrap", 32'(wrap), 32'h0);
        up_down = 0;
        tick;
        chk("flip_dn_q", 32'(q), 32'hc);

        // legal load wins over enable
        load = 1; load_data = 4'h7;
        tick;
        chk("ldok_q", 32'(q), 32'h7);
        chk("ldok_idx", 32'(state_index), 32'h3);
        chk("ldok_dec", 32'(decode), 32'h08);
        chk("ldok_wrap", 32'(wrap), 32'h0);
        chk("ldok_lerr", 32'(load_err), 32'h0);

        // illegal load on both corrected and uncorrected counters
        load_data = 4'h5;
        ld_nc = 1; ldd_nc = 4'h5;
        tick;
        chk("ldbad_q", 32'(q), 32'h0);
        chk("ldbad_lerr", 32'(load_err), 32'h1);
        chk("ldbad_ill", 32'(illegal), 32'h0);
        chk("nc_q", 32'(q_nc), 32'h5);
        chk("nc_ill", 32'(ill_nc), 32'h1);
        chk("nc_dec", 32'(dec_nc), 32'h0);
        chk("nc_idx", 32'(idx_nc), 32'h0);
        chk("nc_lerr", 32'(lerr_nc), 32'h0);
        load = 0; enable = 0;
        ld_nc = 0; en_nc = 1; ud_nc = 1;
        tick;
        chk("lerr_pulse_end", 32'(load_err), 32'h0);
        chk("hold_after_bad", 32'(q), 32'h0);
        chk("nc_raw_step", 32'(q_nc), 32'hb);
        chk("nc_raw_ill", 32'(ill_nc), 32'h1);
        ud_nc = 0;
        tick;
        chk("nc_raw_back", 32'(q_nc), 32'h5);
        chk("nc_raw_wrap", 32'(wrap_nc), 32'h0);
        en_nc = 0;

        // hold at 1110 for three clocks, then async reset
        load = 1; load_data = 4'he;
        tick;
        chk("ld_e", 32'(q), 32'he);
        load = 0; enable = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("hold_q%0d", i), 32'(q), 32'he);
            chk($sformatf("hold_wrap%0d", i), 32'(wrap), 32'h0);
        end
        #3 reset = 1'b1;
        #1 chk("rst3_q", 32'(q), 32'h0);
        chk("rst3_dec", 32'(decode), 32'h01);
        load = 1; load_data = 4'h7; enable = 1; up_down = 1;
        tick;
        chk("rst_ignores_in", 32'(q), 32'h0);
        load = 0;
        reset = 1'b0;
        tick;
        chk("first_step", 32'(q), 32'h1);

        // forward wrap from 1000 then wrap clears on hold
        load = 1; load_data = 4'h8;
        tick;
        chk("ld8_wrap", 32'(wrap), 32'h0);
        load = 0;
        tick;
        chk("wrap8_q", 32'(q), 32'h0);
        chk("wrap8_w", 32'(wrap), 32'h1);
        enable = 0;
        tick;
        chk("wrap_clear", 32'(wrap), 32'h0);

        // WIDTH=2 minimum
        en2 = 1; ud2 = 1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("w2_q%0d", i), 32'(q2), 32'(fw2[i]));
            chk($sformatf("w2_wrap%0d", i), 32'(wrap2), 32'(i == 3));
        end
        en2 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/johnson_counter_param.md
JOHNSON_COUNTER_PARAM -- requirements
Module: johnson_counter_param

Interface
REQ-001: Parameter WIDTH, default 4, sets the counter width; legal range is WIDTH >= 2.
REQ-002: Parameter SELF_CORRECT, default 1; when 1, illegal load values are replaced by zero.
REQ-003: Port clock  input  1  single rising-edge clock for all state.
REQ-004: Port reset  input  1  asynchronous, active-high reset.
REQ-005: Port enable  input  1  when 1, the counter advances one step per clock.
REQ-006: Port up_down  input  1  step direction: 1 = forward, 0 = backward.
REQ-007: Port load  input  1  synchronous load strobe.
REQ-008: Port load_data  input  WIDTH  value written to q when load=1.
REQ-009: Port q  output  WIDTH  registered counter state.
REQ-010: Port state_index  output  $clog2(2*WIDTH)  position of q in the 2*WIDTH sequence; combinational from q.
REQ-011: Port decode  output  2*WIDTH  one-hot of state_index; combinational from q.
REQ-012: Port wrap  output  1  registered one-cycle pulse marking sequence wrap-around.
REQ-013: Port illegal  output  1  combinational flag, high while q is not a legal Johnson state.
REQ-014: Port load_err  output  1  registered one-cycle pulse, high after a load of an illegal value.

Function
REQ-015: Forward step SHALL be q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
REQ-016: Backward step SHALL be q <= {~q[0], q[WIDTH-1:1]}, which is the exact inverse of the forward step.
REQ-017: Legal states SHALL be the 2*WIDTH patterns reached forward from zero: index k (0..WIDTH) = k LSB ones; index WIDTH+j (j=1..WIDTH-1) = ones with j LSB zeros.
REQ-018: Per-clock priority SHALL be load > enable > hold.
REQ-019: Load: if load_data is legal, or SELF_CORRECT=0, q <= load_data; if load_data is illegal and SELF_CORRECT=1, q <= 0 and load_err=1 for one cycle.
REQ-020: A load SHALL NOT step the counter and SHALL NOT assert wrap.
REQ-021: wrap SHALL be 1 in the cycle after an enabled step from index 2*WIDTH-1 to 0 (forward), or from index 0 to 2*WIDTH-1 (backward); otherwise wrap=0.
REQ-022: While q is illegal: illegal=1, decode=all zeros, state_index=0, and enabled steps SHALL apply the raw shift rules.
REQ-023: The up_down value SHALL be sampled on each enabled edge; a direction change SHALL take effect on the very next step with no bubble.
REQ-024: enable=0 with load=0 SHALL hold q and drive wrap=0 and load_err=0.
REQ-025: Latency SHALL be one clock from sampled inputs to q, wrap and load_err; state_index, decode and illegal SHALL follow q within the same cycle.

Reset
REQ-026: reset=1 SHALL immediately, without a clock edge, force q=0, wrap=0 and load_err=0; consequently state_index=0, decode[0]=1 and illegal=0.
REQ-027: Reset asserted mid-count SHALL discard any pending step or load.
REQ-028: While reset=1, all inputs SHALL be ignored; the first step SHALL occur on the first rising edge with reset=0.

Verification (WIDTH=4 unless noted)
REQ-029: Forward count -- reset 10 ns, then enable=1, up_down=1 -> q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap=1 only with the final 0000; decode tracks bit index 1..7 then 0.
REQ-030: Backward count -- from reset, enable=1, up_down=0 -> q = 1000 with wrap=1, then 1100 with wrap=0; state_index goes 7 then 6. Direction flip mid-run -> next q is the predecessor of the current state.
REQ-031: Load legal value -- load=1, load_data=0111, enable=1 -> q=0111, state_index=3, decode=00001000, no step that cycle, wrap=0, load_err=0.
REQ-032: Load illegal value -- load_data=0101 with SELF_CORRECT=1 -> q=0000 and load_err=1 for one cycle. Same load with SELF_CORRECT=0 -> q=0101, illegal=1, decode=0, load_err=0.
REQ-033: Hold and async reset -- enable=0 for 3 clocks -> q unchanged. Then assert reset between clock edges at q=1110 -> q=0000 before the next edge.
REQ-034: Minimum width -- WIDTH=2, enable=1, up_down=1 -> q = 01, 11, 10, 00 with wrap=1 on 00.
